// File: rtl/spi_miso_arbiter_if.sv
// Bus bundle between the slave-side SPI cores and the MISO arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface spi_miso_arbiter_if #(
  parameter int N_SLAVES = 8,
  parameter int CNT_W    = 8
) ();
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  logic [N_SLAVES-1:0] miso_in;
  logic [N_SLAVES-1:0] oen_in;
  logic                cnt_clr;
  logic                miso_out;
  logic                oen_out;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic                conflict;
  logic [CNT_W-1:0]    conflict_cnt;

  modport slave (
    input  miso_in,
    input  oen_in,
    input  cnt_clr,
    output miso_out,
    output oen_out,
    output sel_idx,
    output sel_valid,
    output conflict,
    output conflict_cnt
  );

  modport master (
    output miso_in,
    output oen_in,
    output cnt_clr,
    input  miso_out,
    input  oen_out,
    input  sel_idx,
    input  sel_valid,
    input  conflict,
    input  conflict_cnt
  );
endinterface

// File: rtl/spi_miso_arbiter.sv
// Registered one-hot MISO selector with bus-turnaround gap and
// sticky multi-driver conflict detection plus saturating counter.
module spi_miso_arbiter #(
  parameter int N_SLAVES  = 8,
  parameter int TA_CYCLES = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_miso_arbiter_if.slave bus
);
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam bit TA_ZERO = (TA_CYCLES == 0);
  localparam logic [3:0] TA_LAST =
    TA_ZERO ? 4'd0 : 4'(TA_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_SEL,
    S_CONF
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_nidx;
  logic [3:0]       r_ta;
  logic [3:0]       w_nta;

  logic [N_SLAVES-1:0] w_oen;
  logic                w_zero;
  logic                w_multi;
  logic                w_single;
  logic [IDX_W-1:0]    w_idx;
  logic                w_same;
  logic                w_enter;
  logic                w_miso_sel;

  logic             r_miso;
  logic             r_oen;
  logic             r_valid;
  logic             r_conf;
  logic [CNT_W-1:0] r_cnt;

  assign w_oen    = bus.oen_in;
  assign w_zero   = ~|w_oen;
  // x & (x-1) is nonzero iff two or more bits are set
  assign w_multi  = |(w_oen & (w_oen - 1'b1));
  assign w_single = ~w_zero & ~w_multi;
  assign w_same   = (w_idx == r_idx);

  // OR of set-bit indices: exact when one-hot, no priority chain
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_oen[i]) begin
        w_idx = w_idx | IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_nta    = r_ta;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_multi: w_nstate = S_CONF;
          w_single: begin
            w_nidx   = w_idx;
            w_nta    = '0;
            w_nstate = TA_ZERO ? S_SEL : S_TURN;
          end
          default: w_nstate = S_IDLE;
        endcase
      end
      S_TURN: begin
        unique case (1'b1)
          w_zero:  w_nstate = S_IDLE;
          w_multi: w_nstate = S_CONF;
          default: begin
            if (!w_same) begin
              w_nidx = w_idx;
              w_nta  = '0;
            end else if (r_ta == TA_LAST) begin
              w_nstate = S_SEL;
            end else begin
              w_nta = r_ta + 4'd1;
            end
          end
        endcase
      end
      S_SEL: begin
        unique case (1'b1)
          w_zero:  w_nstate = S_IDLE;
          w_multi: w_nstate = S_CONF;
          default: begin
            if (!w_same) begin
              w_nidx   = w_idx;
              w_nta    = '0;
              w_nstate = TA_ZERO ? S_SEL : S_TURN;
            end
          end
        endcase
      end
      S_CONF: begin
        if (w_zero) begin
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign w_enter    = (w_nstate == S_CONF) && (r_state != S_CONF);
  assign w_miso_sel = bus.miso_in[w_nidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ta    <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_ta    <= w_nta;
    end
  end

  // Outputs come from next-state so the pad sees them one edge after sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oen   <= 1'b0;
      r_miso  <= 1'b0;
      r_valid <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_oen   <= (w_nstate == S_SEL);
      r_miso  <= (w_nstate == S_SEL) ? w_miso_sel : 1'b0;
      r_valid <= (w_nstate == S_SEL) || (w_nstate == S_TURN);
      r_conf  <= (w_nstate == S_CONF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_enter && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.miso_out     = r_miso;
  assign bus.oen_out      = r_oen;
  assign bus.sel_idx      = r_idx;
  assign bus.sel_valid    = r_valid;
  assign bus.conflict     = r_conf;
  assign bus.conflict_cnt = r_cnt;
endmodule
